writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
- Dual-lane writeback stage directly downstream of the load/store unit.
- Consumes the per-lane writeback triples (enable, 5-bit address, 16-bit data) for lanes A and B, and commits them into a 32 x 16 architectural register file.
- Provides four registered read ports to the operand-fetch stage (pOperand/sOperand per lane).
- Keeps a per-register pending-write scoreboard so issue logic can detect RAW hazards and stall.

Parameters:
- NUM_REGS, 32, architectural register count; address width is 5.
- DATA_W, 16, register width.
- PEND_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^PEND_W - 1.
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and issues.

Ports:
- clock_i  in  1  system clock; all state updates on its rising edge
- reset_i  in  1  synchronous, active-high reset
- wbEnableA_i  in  1  lane A writeback valid
- wbAddressA_i  in  5  lane A destination register
- wbDataA_i  in  16  lane A result
- wbEnableB_i  in  1  lane B writeback valid
- wbAddressB_i  in  5  lane B destination register
- wbDataB_i  in  16  lane B result
- rdAddr0_i..rdAddr3_i  in  5 each  read addresses (0/1 = lane A p/s, 2/3 = lane B p/s)
- rdData0_o..rdData3_o  out  16 each  registered read data
- rdBusy0_o..rdBusy3_o  out  1 each  registered: addressed register has pending writes
- issueA_i, issueB_i  in  1 each  instruction with register destination issued this cycle
- issueDestA_i, issueDestB_i  in  5 each  destination of the issued instruction
- issueReady_o  out  1  combinational: both requested issues can be accepted
- conflictCount_o  out  16  saturating count of same-address dual writebacks
- wbOrphan_o  out  1  sticky: a writeback hit a register with pending count 0

Behaviour:
- Reset (reset_i high at an edge):
  - all registers, all pending counters, rdData*_o, rdBusy*_o, conflictCount_o and wbOrphan_o go to 0.
  - Reset overrides every same-cycle write, issue or read.
- Writes:
  - A lane with its enable high writes its data at the edge.
  - If both lanes target the same register, lane B's data wins (B is younger) and conflictCount_o increments, saturating at 16'hFFFF.
  - With ZERO_REG=1, writes to register 0 are dropped and do not count as conflicts.
- Reads:
  - Latency is 1 cycle: the address is sampled at edge N and rdData/rdBusy are valid after edge N.
  - Reads are write-first: a write committing at edge N is visible in the data read at edge N, with lane B priority on address collision.
  - Register 0 always returns 0 when ZERO_REG=1.
- Pending counter update, per register r, every edge:
  - cnt_next = cnt + (issueA & destA==r) + (issueB & destB==r) - (wbEnA & addrA==r) - (wbEnB & addrB==r).
  - Issue and writeback in the same cycle net out; there is no set/clear priority.
  - Issues are counted only when issueReady_o is high. Issue logic must not assert issue while ready is low; if it does, those issues are ignored.
  - A writeback decrement on a counter at 0 clamps at 0 and sets wbOrphan_o, which holds until reset.
- rdBusy*_o is registered from the post-update counter, so it is consistent with rdData*_o.
- issueReady_o is low when any requested destination would exceed the counter max:
  - a single issue is blocked when the counter equals max;
  - both lanes issuing to the same register are blocked when the counter is >= max-1;
  - same-cycle writebacks to that register are not credited.
- Issues to register 0 never change its counter (ZERO_REG=1).

Decomposition:
- Shared package: REG_ADDR_W=5, DATA_W=16, NUM_REGS; reg_addr_t and data_t typedefs; a lane-index enum (LANE_A, LANE_B) reused by the load/store and issue stages.
- One natural sub-module: wb_scoreboard, holding the pending counters, the issueReady logic and the orphan flag.
- The register array, bypass muxing and conflict counter stay in the top module.

Test Plan:
- Reset, then read r5 on all ports -> all rdData=0, rdBusy=0, issueReady=1, conflictCount=0.
- Write A: r3=16'h1234 with same-cycle read of r3 on port 0 -> rdData0=16'h1234 after that edge.
- Both lanes write r7 (A=16'hAAAA, B=16'hBBBB) -> r7 reads 16'hBBBB and conflictCount=1. Repeat to 16'hFFFF -> it stays at 16'hFFFF.
- Issue r9 three times (PEND_W=2) -> rdBusy=1 and the next issue of r9 sees issueReady=0. One writeback to r9 -> ready=1. Three writebacks -> busy=0.
- Same cycle: issueA r4 plus writeback A r4 with counter at 1 -> counter stays 1, busy stays 1, data updated.
- Writeback r12 with no prior issue -> wbOrphan_o=1 and stays 1. Write of 16'hFFFF to r0 -> r0 reads 0. Reset mid-sequence -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// Shared types for the dual-lane writeback stage and its neighbours.
// Holds the register-address and data widths, plus the lane-index enum.
package writeback_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 32;
  localparam int NUM_RD     = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters, the issue-accept check and a sticky orphan-writeback flag.
// Busy is registered (1 cycle). issue_ready_o is combinational, and a low ready drops both issues.
module wb_scoreboard
  import writeback_regfile_pkg::*;
#(
  parameter int PEND_W   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_a_i,
  input  logic [REG_ADDR_W-1:0]        issue_dest_a_i,
  input  logic                         issue_b_i,
  input  logic [REG_ADDR_W-1:0]        issue_dest_b_i,
  input  logic                         wb_en_a_i,
  input  logic [REG_ADDR_W-1:0]        wb_addr_a_i,
  input  logic                         wb_en_b_i,
  input  logic [REG_ADDR_W-1:0]        wb_addr_b_i,
  input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]            rd_busy_o,
  output logic                         issue_ready_o,
  output logic                         orphan_o
);

  localparam int                CW         = PEND_W + 2;
  localparam logic [PEND_W-1:0] CNT_MAX    = '1;
  localparam logic [PEND_W-1:0] CNT_MAX_M1 = CNT_MAX - 1'b1;

  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic [NUM_RD-1:0] busy_q, busy_d;
  logic              orphan_q, orphan_d;

  logic              req_a, req_b, acc_a, acc_b, wbv_a, wbv_b;
  logic [CW-1:0]     up_v, dn_v;

  // Register 0 is invisible to the scoreboard when it is hardwired to zero.
  assign req_a = issue_a_i && !(ZERO_REG && issue_dest_a_i == '0);
  assign req_b = issue_b_i && !(ZERO_REG && issue_dest_b_i == '0);
  assign wbv_a = wb_en_a_i && !(ZERO_REG && wb_addr_a_i == '0);
  assign wbv_b = wb_en_b_i && !(ZERO_REG && wb_addr_b_i == '0);

  always_comb begin
    issue_ready_o = 1'b1;
    if (req_a && req_b && issue_dest_a_i == issue_dest_b_i) begin
      if (cnt_q[issue_dest_a_i] >= CNT_MAX_M1) issue_ready_o = 1'b0;
    end else begin
      if (req_a && cnt_q[issue_dest_a_i] == CNT_MAX) issue_ready_o = 1'b0;
      if (req_b && cnt_q[issue_dest_b_i] == CNT_MAX) issue_ready_o = 1'b0;
    end
  end

  assign acc_a = req_a && issue_ready_o;
  assign acc_b = req_b && issue_ready_o;

  always_comb begin
    orphan_d = orphan_q;
    up_v     = '0;
    dn_v     = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      up_v = {{(CW-PEND_W){1'b0}}, cnt_q[r]};
      dn_v = '0;
      if (acc_a && issue_dest_a_i == REG_ADDR_W'(r)) up_v = up_v + 1'b1;
      if (acc_b && issue_dest_b_i == REG_ADDR_W'(r)) up_v = up_v + 1'b1;
      if (wbv_a && wb_addr_a_i == REG_ADDR_W'(r))    dn_v = dn_v + 1'b1;
      if (wbv_b && wb_addr_b_i == REG_ADDR_W'(r))    dn_v = dn_v + 1'b1;
      // A net decrement below zero means a writeback nobody was waiting on.
      if (dn_v > up_v) begin
        cnt_d[r] = '0;
        orphan_d = 1'b1;
      end else begin
        cnt_d[r] = PEND_W'(up_v - dn_v);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      busy_d[i] = (cnt_d[rd_addr_i[i*REG_ADDR_W +: REG_ADDR_W]] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      busy_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      busy_q   <= busy_d;
      orphan_q <= orphan_d;
    end
  end

  assign rd_busy_o = busy_q;
  assign orphan_o  = orphan_q;

endmodule

// File: rtl/writeback_regfile.sv
// Dual-lane writeback into a 32x16 register file with four write-first read ports and a RAW scoreboard.
// Reads take 1 cycle. There is no backpressure on writeback, and issue is throttled through issueReady_o.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int PEND_W   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  wbEnableA_i,
  input  logic [REG_ADDR_W-1:0] wbAddressA_i,
  input  logic [DATA_W-1:0]     wbDataA_i,
  input  logic                  wbEnableB_i,
  input  logic [REG_ADDR_W-1:0] wbAddressB_i,
  input  logic [DATA_W-1:0]     wbDataB_i,
  input  logic [REG_ADDR_W-1:0] rdAddr0_i,
  input  logic [REG_ADDR_W-1:0] rdAddr1_i,
  input  logic [REG_ADDR_W-1:0] rdAddr2_i,
  input  logic [REG_ADDR_W-1:0] rdAddr3_i,
  output logic [DATA_W-1:0]     rdData0_o,
  output logic [DATA_W-1:0]     rdData1_o,
  output logic [DATA_W-1:0]     rdData2_o,
  output logic [DATA_W-1:0]     rdData3_o,
  output logic                  rdBusy0_o,
  output logic                  rdBusy1_o,
  output logic                  rdBusy2_o,
  output logic                  rdBusy3_o,
  input  logic                  issueA_i,
  input  logic                  issueB_i,
  input  logic [REG_ADDR_W-1:0] issueDestA_i,
  input  logic [REG_ADDR_W-1:0] issueDestB_i,
  output logic                  issueReady_o,
  output logic [15:0]           conflictCount_o,
  output logic                  wbOrphan_o
);

  data_t                         regs_q [NUM_REGS];
  data_t                         regs_d [NUM_REGS];
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_q, rd_data_d;
  logic [15:0]                   conflict_q, conflict_d;
  logic [NUM_RD*REG_ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0]             rd_busy;
  logic                          wr_a, wr_b;

  assign rd_addr = {rdAddr3_i, rdAddr2_i, rdAddr1_i, rdAddr0_i};
  assign wr_a    = wbEnableA_i && !(ZERO_REG && wbAddressA_i == '0);
  assign wr_b    = wbEnableB_i && !(ZERO_REG && wbAddressB_i == '0);

  // Lane B is applied last so it wins a same-address collision, and the
  // read ports sample this post-write view to get write-first behaviour.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
    if (wr_a) regs_d[wbAddressA_i] = wbDataA_i;
    if (wr_b) regs_d[wbAddressB_i] = wbDataB_i;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data_d[i] = regs_d[rd_addr[i*REG_ADDR_W +: REG_ADDR_W]];
      if (ZERO_REG && rd_addr[i*REG_ADDR_W +: REG_ADDR_W] == '0) rd_data_d[i] = '0;
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (wr_a && wr_b && wbAddressA_i == wbAddressB_i && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      rd_data_q  <= '0;
      conflict_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      rd_data_q  <= rd_data_d;
      conflict_q <= conflict_d;
    end
  end

  wb_scoreboard #(
    .PEND_W   (PEND_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i          (clock_i),
    .rst_i          (reset_i),
    .issue_a_i      (issueA_i),
    .issue_dest_a_i (issueDestA_i),
    .issue_b_i      (issueB_i),
    .issue_dest_b_i (issueDestB_i),
    .wb_en_a_i      (wbEnableA_i),
    .wb_addr_a_i    (wbAddressA_i),
    .wb_en_b_i      (wbEnableB_i),
    .wb_addr_b_i    (wbAddressB_i),
    .rd_addr_i      (rd_addr),
    .rd_busy_o      (rd_busy),
    .issue_ready_o  (issueReady_o),
    .orphan_o       (wbOrphan_o)
  );

  assign rdData0_o       = rd_data_q[0];
  assign rdData1_o       = rd_data_q[1];
  assign rdData2_o       = rd_data_q[2];
  assign rdData3_o       = rd_data_q[3];
  assign rdBusy0_o       = rd_busy[0];
  assign rdBusy1_o       = rd_busy[1];
  assign rdBusy2_o       = rd_busy[2];
  assign rdBusy3_o       = rd_busy[3];
  assign conflictCount_o = conflict_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed vector bench for writeback_regfile: table of single-cycle vectors plus reset and saturation sequences.
module tb_writeback_regfile;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        wbEnableA_i, wbEnableB_i;
  logic [4:0]  wbAddressA_i, wbAddressB_i;
  logic [15:0] wbDataA_i, wbDataB_i;
  logic [4:0]  rdAddr0_i, rdAddr1_i, rdAddr2_i, rdAddr3_i;
  logic [15:0] rdData0_o, rdData1_o, rdData2_o, rdData3_o;
  logic        rdBusy0_o, rdBusy1_o, rdBusy2_o, rdBusy3_o;
  logic        issueA_i, issueB_i;
  logic [4:0]  issueDestA_i, issueDestB_i;
  logic        issueReady_o;
  logic [15:0] conflictCount_o;
  logic        wbOrphan_o;

  int errors = 0;
  int checks = 0;

  writeback_regfile dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .wbEnableA_i     (wbEnableA_i),
    .wbAddressA_i    (wbAddressA_i),
    .wbDataA_i       (wbDataA_i),
    .wbEnableB_i     (wbEnableB_i),
    .wbAddressB_i    (wbAddressB_i),
    .wbDataB_i       (wbDataB_i),
    .rdAddr0_i       (rdAddr0_i),
    .rdAddr1_i       (rdAddr1_i),
    .rdAddr2_i       (rdAddr2_i),
    .rdAddr3_i       (rdAddr3_i),
    .rdData0_o       (rdData0_o),
    .rdData1_o       (rdData1_o),
    .rdData2_o       (rdData2_o),
    .rdData3_o       (rdData3_o),
    .rdBusy0_o       (rdBusy0_o),
    .rdBusy1_o       (rdBusy1_o),
    .rdBusy2_o       (rdBusy2_o),
    .rdBusy3_o       (rdBusy3_o),
    .issueA_i        (issueA_i),
    .issueB_i        (issueB_i),
    .issueDestA_i    (issueDestA_i),
    .issueDestB_i    (issueDestB_i),
    .issueReady_o    (issueReady_o),
    .conflictCount_o (conflictCount_o),
    .wbOrphan_o      (wbOrphan_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic        wea;
    logic [4:0]  aa;
    logic [15:0] da;
    logic        web;
    logic [4:0]  ab;
    logic [15:0] db;
    logic        ia;
    logic [4:0]  ida;
    logic        ib;
    logic [4:0]  idb;
    logic [4:0]  ra0;
    logic [4:0]  ra3;
    logic        rdy;
    logic [15:0] d0;
    logic        b0;
    logic [15:0] d3;
    logic        b3;
    logic [15:0] cc;
    logic        orph;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(logic wea, logic [4:0] aa, logic [15:0] da,
                              logic web, logic [4:0] ab, logic [15:0] db,
                              logic ia, logic [4:0] ida, logic ib, logic [4:0] idb,
                              logic [4:0] ra0, logic [4:0] ra3, logic rdy,
                              logic [15:0] d0, logic b0, logic [15:0] d3, logic b3,
                              logic [15:0] cc, logic orph);
    vec_t v;
    v.wea = wea; v.aa = aa; v.da = da; v.web = web; v.ab = ab; v.db = db;
    v.ia = ia; v.ida = ida; v.ib = ib; v.idb = idb; v.ra0 = ra0; v.ra3 = ra3;
    v.rdy = rdy; v.d0 = d0; v.b0 = b0; v.d3 = d3; v.b3 = b3; v.cc = cc; v.orph = orph;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wbEnableA_i = v.wea; wbAddressA_i = v.aa; wbDataA_i = v.da;
    wbEnableB_i = v.web; wbAddressB_i = v.ab; wbDataB_i = v.db;
    issueA_i = v.ia; issueDestA_i = v.ida; issueB_i = v.ib; issueDestB_i = v.idb;
    rdAddr0_i = v.ra0; rdAddr1_i = v.ra0; rdAddr2_i = v.ra3; rdAddr3_i = v.ra3;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0,0,0,0, 0,0, 1, 0,0,0,0, 0,0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    //             wea aa da        web ab db        ia ida ib idb  ra0 ra3 rdy d0       b0 d3       b3 cc orph
    tbl[0]  = mk(0,0,0,          0,0,0,           0,0,0,0,      5,5,  1, 0,0,          0,0,          0,0);
    tbl[1]  = mk(0,0,0,          0,0,0,           1,3,0,0,      3,3,  1, 0,1,          0,1,          0,0);
    tbl[2]  = mk(1,3,16'h1234,   0,0,0,           0,0,0,0,      3,3,  1, 16'h1234,0,   16'h1234,0,   0,0);
    tbl[3]  = mk(0,0,0,          0,0,0,           1,7,1,7,      7,3,  1, 0,1,          16'h1234,0,   0,0);
    tbl[4]  = mk(1,7,16'hAAAA,   1,7,16'hBBBB,    0,0,0,0,      7,7,  1, 16'hBBBB,0,   16'hBBBB,0,   1,0);
    tbl[5]  = mk(0,0,0,          0,0,0,           1,9,0,0,      9,9,  1, 0,1,          0,1,          1,0);
    tbl[6]  = mk(0,0,0,          0,0,0,           1,9,0,0,      9,9,  1, 0,1,          0,1,          1,0);
    tbl[7]  = mk(0,0,0,          0,0,0,           1,9,0,0,      9,9,  1, 0,1,          0,1,          1,0);
    tbl[8]  = mk(0,0,0,          0,0,0,           1,9,0,0,      9,9,  0, 0,1,          0,1,          1,0);
    tbl[9]  = mk(1,9,16'h0909,   0,0,0,           0,0,0,0,      9,9,  1, 16'h0909,1,   16'h0909,1,   1,0);
    tbl[10] = mk(0,0,0,          0,0,0,           1,9,1,9,      9,9,  0, 16'h0909,1,   16'h0909,1,   1,0);
    tbl[11] = mk(0,0,0,          1,9,16'h9999,    1,9,0,0,      9,9,  1, 16'h9999,1,   16'h9999,1,   1,0);
    tbl[12] = mk(1,9,16'h1111,   0,0,0,           0,0,0,0,      9,9,  1, 16'h1111,1,   16'h1111,1,   1,0);
    tbl[13] = mk(1,9,16'h2222,   0,0,0,           0,0,0,0,      9,9,  1, 16'h2222,0,   16'h2222,0,   1,0);
    tbl[14] = mk(0,0,0,          0,0,0,           1,4,0,0,      4,9,  1, 0,1,          16'h2222,0,   1,0);
    tbl[15] = mk(1,4,16'h4444,   0,0,0,           1,4,0,0,      4,4,  1, 16'h4444,1,   16'h4444,1,   1,0);
    tbl[16] = mk(0,0,0,          1,12,16'h0C0C,   0,0,0,0,      12,4, 1, 16'h0C0C,0,   16'h4444,1,   1,1);
    tbl[17] = mk(1,0,16'hFFFF,   0,0,0,           0,0,0,0,      0,12, 1, 0,0,          16'h0C0C,0,   1,1);
    tbl[18] = mk(1,0,16'h0001,   1,0,16'h0002,    0,0,0,0,      0,0,  1, 0,0,          0,0,          1,1);
    tbl[19] = mk(0,0,0,          0,0,0,           1,0,1,0,      0,4,  1, 0,0,          16'h4444,1,   1,1);
    tbl[20] = mk(1,20,16'h2020,  1,21,16'h2121,   1,20,1,21,    20,21,1, 16'h2020,0,   16'h2121,0,   1,1);

    reset_i = 1'b1;
    idle();
    repeat (2) @(posedge clock_i);
    #1;
    reset_i = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d issueReady", i), {15'd0, issueReady_o}, {15'd0, tbl[i].rdy});
      @(posedge clock_i);
      #1;
      chk($sformatf("v%0d rdData0", i), rdData0_o, tbl[i].d0);
      chk($sformatf("v%0d rdData1", i), rdData1_o, tbl[i].d0);
      chk($sformatf("v%0d rdData2", i), rdData2_o, tbl[i].d3);
      chk($sformatf("v%0d rdData3", i), rdData3_o, tbl[i].d3);
      chk($sformatf("v%0d rdBusy0", i), {15'd0, rdBusy0_o}, {15'd0, tbl[i].b0});
      chk($sformatf("v%0d rdBusy1", i), {15'd0, rdBusy1_o}, {15'd0, tbl[i].b0});
      chk($sformatf("v%0d rdBusy2", i), {15'd0, rdBusy2_o}, {15'd0, tbl[i].b3});
      chk($sformatf("v%0d rdBusy3", i), {15'd0, rdBusy3_o}, {15'd0, tbl[i].b3});
      chk($sformatf("v%0d conflictCount", i), conflictCount_o, tbl[i].cc);
      chk($sformatf("v%0d wbOrphan", i), {15'd0, wbOrphan_o}, {15'd0, tbl[i].orph});
    end

    // Reset asserted alongside a write, an issue and a read: the reset wins.
    drive(mk(1,3,16'h5555, 0,0,0, 1,4,0,0, 3,4, 1, 0,0,0,0, 0,0));
    reset_i = 1'b1;
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    chk("rst rdData0", rdData0_o, 16'h0000);
    chk("rst rdBusy3", {15'd0, rdBusy3_o}, 16'd0);
    chk("rst conflictCount", conflictCount_o, 16'h0000);
    chk("rst wbOrphan", {15'd0, wbOrphan_o}, 16'd0);
    drive(mk(0,0,0, 0,0,0, 0,0,0,0, 3,4, 1, 0,0,0,0, 0,0));
    #1;
    chk("post-rst issueReady", {15'd0, issueReady_o}, 16'd1);
    @(posedge clock_i);
    #1;
    chk("post-rst r3 cleared", rdData0_o, 16'h0000);
    chk("post-rst r4 not busy", {15'd0, rdBusy3_o}, 16'd0);

    // 65535 balanced dual issue + dual writeback cycles on r7 drive the
    // conflict counter to saturation without touching the orphan flag.
    for (int n = 0; n < 65535; n++) begin
      drive(mk(1,7,16'(n), 1,7,16'(~n), 1,7,1,7, 7,7, 1, 0,0,0,0, 0,0));
      @(posedge clock_i);
      #1;
    end
    chk("sat conflictCount", conflictCount_o, 16'hFFFF);
    chk("sat r7 lane B data", rdData0_o, 16'h0001);
    for (int n = 0; n < 2; n++) begin
      drive(mk(1,7,16'h00AA, 1,7,16'h00BB, 1,7,1,7, 7,7, 1, 0,0,0,0, 0,0));
      @(posedge clock_i);
      #1;
      chk($sformatf("sat hold %0d", n), conflictCount_o, 16'hFFFF);
    end
    chk("sat r7 busy", {15'd0, rdBusy0_o}, 16'd0);
    chk("sat wbOrphan", {15'd0, wbOrphan_o}, 16'd0);
    idle();
    @(posedge clock_i);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
